// File: rtl/ser_frame_pkg.sv
// Purpose: shared types and default parameters for the serial frame demultiplexer.
// Contents: FSM state enum, default parameter constants, width helper.
package ser_frame_pkg;

  localparam int unsigned DEF_N_CH        = 4;
  localparam int unsigned DEF_LEN_W       = 4;
  localparam int unsigned DEF_PARITY_EN   = 1;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CH   = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_PAR  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  // Larger of two widths, used to size the shared header bit counter.
  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pb_edge_sync.sv
// Purpose: synchronise the push-button strobe and serial data into clk and
//          detect rising strobe edges, only once a genuine low has been seen.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   i_pb           asynchronous bit strobe
//   i_ser          asynchronous serial data
//   o_bit_stb_c    one-cycle strobe (combinational from sync registers)
//   o_bit_val      serial data aligned with o_bit_stb_c
module pb_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pb,
  input  logic i_ser,
  output logic o_bit_stb_c,
  output logic o_bit_val
);

  logic [SYNC_STAGES-1:0] r_pb_sync;
  logic [SYNC_STAGES-1:0] r_ser_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_pb_d;
  logic                   r_armed;
  logic                   w_pb_s;

  assign w_pb_s = r_pb_sync[SYNC_STAGES-1];

  // r_fill marks when the sync output reflects a real sample rather than the
  // reset value, so a strobe held high through reset cannot arm the detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pb_sync  <= '0;
      r_ser_sync <= '0;
      r_fill     <= '0;
      r_pb_d     <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_pb_sync  <= {r_pb_sync[SYNC_STAGES-2:0], i_pb};
      r_ser_sync <= {r_ser_sync[SYNC_STAGES-2:0], i_ser};
      r_fill     <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_pb_d     <= w_pb_s;
      if (r_fill[SYNC_STAGES-1] && !w_pb_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_bit_stb_c = w_pb_s & ~r_pb_d & r_armed;
  assign o_bit_val   = r_ser_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ser_frame_demux.sv
// Purpose: framed serial receiver; parses start/channel/length header, routes
//          data bits to the addressed channel, optionally checks even parity.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   clkPB        asynchronous bit strobe (one bit per rising edge)
//   Ser_In       asynchronous serial data
//   p            per-channel data, only the addressed bit may be set
//   SerOutValid  pulse per routed data bit
//   cnt_left     data bits remaining in the frame
//   busy         FSM not idle
//   done         pulse one cycle after the frame completes
//   par_err      parity mismatch on the last frame
module ser_frame_demux
  import ser_frame_pkg::*;
#(
  parameter int unsigned N_CH        = DEF_N_CH,
  parameter int unsigned LEN_W       = DEF_LEN_W,
  parameter int unsigned PARITY_EN   = DEF_PARITY_EN,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkPB,
  input  logic             Ser_In,
  output logic [N_CH-1:0]  p,
  output logic             SerOutValid,
  output logic [LEN_W-1:0] cnt_left,
  output logic             busy,
  output logic             done,
  output logic             par_err
);

  localparam int unsigned CH_W  = $clog2(N_CH);
  localparam int unsigned CNT_W = max_w(CH_W, LEN_W);

  logic w_bit_stb;
  logic w_bit_val;

  pb_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_pb       (clkPB),
    .i_ser      (Ser_In),
    .o_bit_stb_c(w_bit_stb),
    .o_bit_val  (w_bit_val)
  );

  state_e           r_state,     w_state_nxt;
  logic [CH_W-1:0]  r_ch,        w_ch_nxt;
  logic [LEN_W-1:0] r_len,       w_len_nxt;
  logic [CNT_W-1:0] r_bit_cnt,   w_bit_cnt_nxt;
  logic             r_par,       w_par_nxt;
  logic [N_CH-1:0]  r_p,         w_p_nxt;
  logic             r_valid,     w_valid_nxt;
  logic [LEN_W-1:0] r_cnt_left,  w_cnt_left_nxt;
  logic             r_busy,      w_busy_nxt;
  logic             r_done,      w_done_nxt;
  logic             r_par_err,   w_par_err_nxt;

  logic [CH_W-1:0]  w_ch_shift;
  logic [LEN_W-1:0] w_len_shift;
  logic             w_last_ch;
  logic             w_last_len;
  state_e           w_end_state;

  // Header fields shift MSB first; casts keep the low bits of {reg, new bit}.
  assign w_ch_shift  = CH_W'({r_ch, w_bit_val});
  assign w_len_shift = LEN_W'({r_len, w_bit_val});
  assign w_last_ch   = (r_bit_cnt == CNT_W'(CH_W - 1));
  assign w_last_len  = (r_bit_cnt == CNT_W'(LEN_W - 1));
  assign w_end_state = (PARITY_EN != 0) ? S_PAR : S_DONE;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ch       <= '0;
      r_len      <= '0;
      r_bit_cnt  <= '0;
      r_par      <= 1'b0;
      r_p        <= '0;
      r_valid    <= 1'b0;
      r_cnt_left <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_par_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ch       <= w_ch_nxt;
      r_len      <= w_len_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_par      <= w_par_nxt;
      r_p        <= w_p_nxt;
      r_valid    <= w_valid_nxt;
      r_cnt_left <= w_cnt_left_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_par_err  <= w_par_err_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_ch_nxt       = r_ch;
    w_len_nxt      = r_len;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_par_nxt      = r_par;
    w_p_nxt        = r_p;
    w_valid_nxt    = 1'b0;
    w_cnt_left_nxt = r_cnt_left;
    w_par_err_nxt  = r_par_err;
    // done trails the DONE state by a cycle so it never overlaps the last data pulse
    w_done_nxt     = (r_state == S_DONE);

    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_state == S_DONE) begin
          w_state_nxt = S_IDLE;
        end
        if (w_bit_stb && !w_bit_val) begin
          w_state_nxt    = S_CH;
          w_p_nxt        = '0;
          w_par_err_nxt  = 1'b0;
          w_par_nxt      = 1'b0;
          w_ch_nxt       = '0;
          w_len_nxt      = '0;
          w_bit_cnt_nxt  = '0;
          w_cnt_left_nxt = '0;
        end
      end
      S_CH: begin
        if (w_bit_stb) begin
          w_ch_nxt = w_ch_shift;
          if (w_last_ch) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = S_LEN;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          end
        end
      end
      S_LEN: begin
        if (w_bit_stb) begin
          w_len_nxt = w_len_shift;
          if (w_last_len) begin
            w_bit_cnt_nxt  = '0;
            w_cnt_left_nxt = w_len_shift;
            w_state_nxt    = (w_len_shift == '0) ? w_end_state : S_DATA;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (w_bit_stb) begin
          w_p_nxt        = '0;
          w_p_nxt[r_ch]  = w_bit_val;
          w_valid_nxt    = 1'b1;
          w_par_nxt      = r_par ^ w_bit_val;
          w_cnt_left_nxt = r_cnt_left - LEN_W'(1);
          if (r_cnt_left == LEN_W'(1)) begin
            w_state_nxt = w_end_state;
          end
        end
      end
      S_PAR: begin
        if (w_bit_stb) begin
          w_par_err_nxt = w_bit_val ^ r_par;
          w_state_nxt   = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign p           = r_p;
  assign SerOutValid = r_valid;
  assign cnt_left    = r_cnt_left;
  assign busy        = r_busy;
  assign done        = r_done;
  assign par_err     = r_par_err;

endmodule
